// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_frame serial-to-parallel frame assembler.
// Optional parity support in sipo_frame is enabled with SIPO_PARITY_EN.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic MODE_RIGHT = 1'b0;
  localparam logic MODE_LEFT  = 1'b1;

  // A length of zero or one beyond the word width means "use the full word".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
    int unsigned res;
    if (len == 0 || len > width) begin
      res = width;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and last-bit strobe for sipo_frame.
// Shifts right (si into MSB) or left (si into LSB) depending on the latched mode.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             mode,
  input  logic             si,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] sr,
  output logic [WIDTH-1:0] sr_next,
  output logic             data_full,
  output logic             done
);

  logic [WIDTH-1:0] sr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic left_in;
      logic right_in;
      if (gi == 0) begin : g_lsb
        assign left_in = si;
      end else begin : g_lmid
        assign left_in = sr_reg[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_msb
        assign right_in = si;
      end else begin : g_rmid
        assign right_in = sr_reg[gi+1];
      end
      assign sr_next[gi] = (mode == MODE_LEFT) ? left_in : right_in;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
    end else if (clr) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
    end else if (shift_en) begin
      sr_reg  <= sr_next;
      cnt_reg <= cnt_inc;
    end
  end

  assign cnt_inc   = cnt_reg + CNT_W'(1);
  assign sr        = sr_reg;
  assign data_full = (cnt_reg == len);
  assign done      = shift_en && (cnt_inc == len);

endmodule

// File: rtl/sipo_frame.sv
// Programmable-length serial-in/parallel-out frame assembler with valid/ready output.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per frame and report par_err.
module sipo_frame
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] len,
  input  logic             si,
  input  logic             si_valid,
  output logic             si_ready,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             par_err
);

  state_t           state_reg, state_next;
  logic             mode_reg;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] len_clamped;
  logic             start_ok;
  logic             xfer;
  logic             shift_en;
  logic             data_full;
  logic             done_core;
  logic             frame_done;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] frame_word;
  logic             load;
  logic [WIDTH-1:0] po_reg;
  logic             po_valid_reg, po_valid_next;

  assign len_clamped = CNT_W'(clamp_len(32'(len), 32'(WIDTH)));
  assign start_ok    = start && (state_reg == IDLE);
  assign si_ready    = (state_reg == SHIFT);
  assign xfer        = si_valid && si_ready;
  // Once all data bits are in, further transfers (the parity bit) are not stored.
  assign shift_en    = xfer && !data_full;
  // On the final data transfer the word is still one shift away inside the core.
  assign frame_word  = data_full ? sr : sr_next;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .shift_en  (shift_en),
    .mode      (mode_reg),
    .si        (si),
    .len       (len_reg),
    .sr        (sr),
    .sr_next   (sr_next),
    .data_full (data_full),
    .done      (done_core)
  );

`ifdef SIPO_PARITY_EN
  logic par_acc_reg;
  logic par_err_reg;
  logic par_err_next;

  assign frame_done   = xfer && data_full;
  assign par_err_next = (state_reg == SHIFT) ? (par_acc_reg ^ si) : par_acc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_acc_reg <= 1'b0;
      par_err_reg <= 1'b0;
    end else begin
      if (start_ok) begin
        par_acc_reg <= 1'b0;
      end else if (xfer) begin
        par_acc_reg <= par_acc_reg ^ si;
      end
      if (load) begin
        par_err_reg <= par_err_next;
      end
    end
  end

  assign par_err = par_err_reg;
`else
  assign frame_done = done_core;
  assign par_err    = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    load          = 1'b0;
    po_valid_next = po_valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_done) begin
          if (!po_valid_reg || po_ready) begin
            load       = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = FULL;
          end
        end
      end
      FULL: begin
        if (po_ready) begin
          load       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      po_valid_next = 1'b1;
    end else if (po_valid_reg && po_ready) begin
      po_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_reg     <= MODE_RIGHT;
      len_reg      <= CNT_W'(WIDTH);
      po_reg       <= '0;
      po_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      po_valid_reg <= po_valid_next;
      if (start_ok) begin
        mode_reg <= mode;
        len_reg  <= len_clamped;
      end
      if (load) begin
        po_reg <= frame_word;
      end
    end
  end

  assign po       = po_reg;
  assign po_valid = po_valid_reg;
  assign busy     = (state_reg != IDLE);

endmodule
